// File: rtl/reg16_bus_pkg.sv
// Shared types and constants for the 16-bit register bus master.
package reg16_bus_pkg;

  localparam int HALF_W  = 16;
  localparam int BE_HALF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/reg16_bus_master.sv
// Splits 32-bit byte-enabled requests into low/high 16-bit Avalon-MM
// transactions and returns one response per request.
module reg16_bus_master
  import reg16_bus_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_write,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [2*HALF_W-1:0]       req_data,
  input  logic [2*BE_HALF-1:0]      req_be,
  output logic                      rsp_valid,
  output logic [2*HALF_W-1:0]       rsp_data,
  output logic [ADDR_W:0]           avm_address,
  output logic                      avm_write,
  output logic                      avm_read,
  output logic [BE_HALF-1:0]        avm_byteenable,
  output logic [HALF_W-1:0]         avm_writedata,
  input  logic [HALF_W-1:0]         avm_readdata,
  input  logic                      avm_waitrequest
);

  state_t              r_state;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [2*HALF_W-1:0] r_rsp_data;
  logic [ADDR_W:0]     r_avm_address;
  logic                r_avm_write;
  logic                r_avm_read;
  logic [BE_HALF-1:0]  r_avm_byteenable;
  logic [HALF_W-1:0]   r_avm_writedata;

  // Only the high half of the request needs to survive past acceptance;
  // the low half is loaded straight onto the bus registers.
  logic [ADDR_W-1:0]   r_addr;
  logic [HALF_W-1:0]   r_hi_data;
  logic [BE_HALF-1:0]  r_hi_be;

  logic w_accept;
  logic w_lo_en;
  logic w_hi_en;

  assign w_accept = (r_state == IDLE) && r_req_ready && req_valid;
  assign w_lo_en  = |req_be[BE_HALF-1:0];
  assign w_hi_en  = |req_be[2*BE_HALF-1:BE_HALF];

  // NOTE: every register below is state, so it is updated with <= only;
  // mixing blocking assignments here would create order-dependent races.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state          <= IDLE;
      r_req_ready      <= 1'b0;
      r_rsp_valid      <= 1'b0;
      r_rsp_data       <= '0;
      r_avm_address    <= '0;
      r_avm_write      <= 1'b0;
      r_avm_read       <= 1'b0;
      r_avm_byteenable <= '0;
      r_avm_writedata  <= '0;
      r_addr           <= '0;
      r_hi_data        <= '0;
      r_hi_be          <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_rsp_data  <= '0;
            r_addr      <= req_addr;
            r_hi_data   <= req_data[2*HALF_W-1:HALF_W];
            r_hi_be     <= req_be[2*BE_HALF-1:BE_HALF];
            if (w_lo_en) begin
              r_state          <= LOW;
              r_avm_address    <= {req_addr, 1'b0};
              r_avm_byteenable <= req_be[BE_HALF-1:0];
              r_avm_writedata  <= req_data[HALF_W-1:0];
              r_avm_write      <= req_write;
              r_avm_read       <= ~req_write;
            end else if (w_hi_en) begin
              r_state          <= HIGH;
              r_avm_address    <= {req_addr, 1'b1};
              r_avm_byteenable <= req_be[2*BE_HALF-1:BE_HALF];
              r_avm_writedata  <= req_data[2*HALF_W-1:HALF_W];
              r_avm_write      <= req_write;
              r_avm_read       <= ~req_write;
            end else begin
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
            end
          end else begin
            // Ready rises one cycle after reset releases.
            r_req_ready <= 1'b1;
          end
        end

        LOW: begin
          if (!avm_waitrequest) begin
            if (r_avm_read) r_rsp_data[HALF_W-1:0] <= avm_readdata;
            if (|r_hi_be) begin
              r_state          <= HIGH;
              r_avm_address    <= {r_addr, 1'b1};
              r_avm_byteenable <= r_hi_be;
              r_avm_writedata  <= r_hi_data;
            end else begin
              r_state     <= RESP;
              r_avm_write <= 1'b0;
              r_avm_read  <= 1'b0;
              r_rsp_valid <= 1'b1;
            end
          end
        end

        HIGH: begin
          if (!avm_waitrequest) begin
            if (r_avm_read) r_rsp_data[2*HALF_W-1:HALF_W] <= avm_readdata;
            r_state     <= RESP;
            r_avm_write <= 1'b0;
            r_avm_read  <= 1'b0;
            r_rsp_valid <= 1'b1;
          end
        end

        RESP: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign avm_address    = r_avm_address;
  assign avm_write      = r_avm_write;
  assign avm_read       = r_avm_read;
  assign avm_byteenable = r_avm_byteenable;
  assign avm_writedata  = r_avm_writedata;

endmodule

// File: doc/reg16_bus_master.md
Name: reg16_bus_master

Overview:
- Initiator-side counterpart to the 16-bit byte-enabled register slaves in the multiple-port register component.
- Accepts 32-bit read/write requests over a valid/ready interface.
- Splits each request into up to two 16-bit Avalon-MM transactions (low half, then high half) with per-byte enables, honouring avm_waitrequest.
- Returns one response per request; sits between a control processor/bridge and the register bank.

Parameters:
ADDR_W, 8, width of request word address; Avalon address is ADDR_W+1 bits (16-bit word granularity).

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request (high only in IDLE)
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  32-bit word address
req_data  in  32  write data
req_be  in  4  byte enables; [1:0] low half, [3:2] high half
rsp_valid  out  1  one-cycle pulse: request completed
rsp_data  out  32  read data; skipped halves read as 0; 0 for writes
avm_address  out  ADDR_W+1  16-bit word address
avm_write  out  1  Avalon write strobe
avm_read  out  1  Avalon read strobe
avm_byteenable  out  2  Avalon byte enables
avm_writedata  out  16  Avalon write data
avm_readdata  in  16  Avalon read data, valid when avm_read=1 and avm_waitrequest=0
avm_waitrequest  in  1  slave stall

Behaviour:
- Reset (sync, high): state=IDLE; req_ready=0 during reset cycle, then 1; rsp_valid=0; rsp_data=0; avm_write=avm_read=0; avm_address=0; avm_byteenable=0; avm_writedata=0.
- Reset asserted mid-operation: next edge forces IDLE, drops strobes; no response emitted; the in-flight transaction is abandoned.
- States: IDLE, LOW, HIGH, RESP.
- IDLE: req_ready=1. On req_valid, latch write/addr/data/be.
  - be[1:0]!=0 -> LOW.
  - else be[3:2]!=0 -> HIGH.
  - else (be==0) -> RESP (no bus access, rsp_data=0).
- LOW: drive avm_address={addr,1'b0}, avm_byteenable=be[1:0], avm_writedata=data[15:0], avm_write or avm_read per req_write. All outputs held stable while avm_waitrequest=1. On avm_waitrequest=0:
  - read: capture avm_readdata into rsp_data[15:0].
  - go to HIGH if be[3:2]!=0, else RESP.
- HIGH: as LOW with address {addr,1'b1}, be[3:2], data[31:16]; read captures into rsp_data[31:16]. On waitrequest=0 -> RESP.
- RESP: strobes low; rsp_valid=1 for exactly one cycle -> IDLE.
- rsp_data cleared to 0 on request acceptance; holds value after RESP until the next acceptance.
- Strobes are registered: never both read and write; deasserted in the cycle after completion.
- Zero-wait latency: accept at edge N, LOW N+1, HIGH N+2, rsp_valid N+3, req_ready N+4. Full-word throughput is one request per 4 cycles.
- Address wrap: addr all-ones maps to avm_address max-1/max; no overflow logic.
- Ignored inputs: req_data is ignored for reads; req_* are ignored outside IDLE.

Decomposition:
- Shared package reg16_bus_pkg: state enum (IDLE, LOW, HIGH, RESP), HALF_W=16, BE_HALF=2.
- Single flat module; no sub-module warranted.

Test Plan:
- Write addr=0x05, data=0xA1B2C3D4, be=4'hF, waitrequest=0 -> write addr 0x0A be=2'b11 data 0xC3D4, then 0x0B data 0xA1B2; rsp_valid at cycle 3 after accept.
- Write be=4'b1100, data=0x12345678, addr=0x02 -> single write, addr 0x05, be=2'b11, data 0x1234; low half untouched; rsp_valid one cycle later.
- Read addr=0x03, be=4'hF, slave returns 0xBEEF (0x06) then 0xCAFE (0x07), waitrequest high 3 cycles on the first -> rsp_data=0xCAFEBEEF; address/strobe stable during stall.
- Read be=4'b0001 -> one read with avm_byteenable=2'b01; rsp_data[31:16]=0.
- req_be=0 -> no avm strobe; rsp_valid one cycle after next edge; rsp_data=0.
- Assert reset during HIGH with waitrequest=1 -> next cycle strobes 0, no rsp_valid, req_ready=1 after reset released.
